// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory-access path and mem_responder.
// The req_be lane-enable signal exists only when MEM_BYTE_STROBE_EN is defined.
interface mem_responder_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
`ifdef MEM_BYTE_STROBE_EN
   logic [3:0]  req_be;
`endif
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

`ifdef MEM_BYTE_STROBE_EN
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`else
   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`endif
endinterface

// File: rtl/mem_responder.sv
// Word-organised memory responder: one request at a time, WAIT wait states, one-cycle response.
// Optional per-byte write enables when MEM_BYTE_STROBE_EN is defined.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// BUSY  | request latched, counting down wait states
// RESP  | rsp_valid pulse; a pending aligned write commits on the edge leaving this state
module mem_responder #(
   parameter int ADDR_W = 6,
   parameter int WAIT   = 2
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              lat_write;
   logic              lat_mis;
   logic [ADDR_W-1:0] lat_idx;
   logic [31:0]       lat_wdata;
   logic [3:0]        lat_be;

   logic              ready_q;
   logic              rsp_valid_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [31:0]       mem [2**ADDR_W];

   logic [ADDR_W-1:0] req_idx;
   logic              req_mis;
   logic [3:0]        req_be_s;

   assign req_idx = bus.req_addr[ADDR_W+1:2];
   assign req_mis = |bus.req_addr[1:0];

`ifdef MEM_BYTE_STROBE_EN
   assign req_be_s = bus.req_be;
`else
   assign req_be_s = 4'hF;
`endif

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         lat_write   <= 1'b0;
         lat_mis     <= 1'b0;
         lat_idx     <= '0;
         lat_wdata   <= 32'd0;
         lat_be      <= 4'd0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_write <= bus.req_write;
                  lat_mis   <= req_mis;
                  lat_idx   <= req_idx;
                  lat_wdata <= bus.req_wdata;
                  lat_be    <= req_be_s;
                  ready_q   <= 1'b0;
                  if (WAIT == 0) begin
                     state       <= RESP;
                     rsp_valid_q <= 1'b1;
                     err_q       <= req_mis;
                     rdata_q     <= (bus.req_write || req_mis) ? 32'd0 : mem[req_idx];
                  end else begin
                     state <= BUSY;
                     cnt   <= 4'(WAIT - 1);
                  end
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  err_q       <= lat_mis;
                  rdata_q     <= (lat_write || lat_mis) ? 32'd0 : mem[lat_idx];
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state       <= IDLE;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b0;
               rdata_q     <= 32'd0;
               err_q       <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               cnt         <= 4'd0;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b0;
               rdata_q     <= 32'd0;
               err_q       <= 1'b0;
            end
         endcase
      end
   end

   // Array is deliberately not reset; an async reset forces state to IDLE, so an
   // in-flight write can never reach the commit below.
   always_ff @(posedge clk) begin
      if (state == RESP && lat_write && !lat_mis) begin
`ifdef MEM_BYTE_STROBE_EN
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
         end
`else
         mem[lat_idx] <= lat_wdata;
`endif
      end
   end

endmodule
